// File: rtl/uart_tx_fifo_if.sv
// Write-side and status signals of uart_tx_fifo: the CPU store path pushes bytes
// and polls status, the slave side drives the TX line.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  logic                          write_en;
  logic [DATA_BITS-1:0]          data;
  logic                          tx;
  logic                          uart_busy;
  logic                          fifo_full;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          overflow;

  modport master (
    output write_en, data,
    input  tx, uart_busy, fifo_full, fifo_count, overflow
  );

  modport slave (
    input  write_en, data,
    output tx, uart_busy, fifo_full, fifo_count, overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a write FIFO, configurable data width, optional parity
// and 1 or 2 stop bits; every output is registered.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input logic           clk,
  input logic           rst,
  uart_tx_fifo_if.slave bus
);
  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CW       = AW + 1;
  localparam int BW       = $clog2(BAUD_DIV);
  localparam int IW       = $clog2(DATA_BITS);

  localparam logic [BW-1:0] BAUD_LAST  = BW'(BAUD_DIV - 1);
  localparam logic [IW-1:0] BIT_LAST   = IW'(DATA_BITS - 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic          HAS_PARITY = (PARITY != 0);
  localparam logic          ODD_PARITY = (PARITY == 2);
  localparam logic          STOP_LAST  = (STOP_BITS == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count, count_next;

  state_t               state;
  logic [BW-1:0]        baud_cnt;
  logic [IW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;

  logic                 tx_q, busy_q, full_q, ovf_q;
  logic                 push, pop, baud_end, frame_done;

  // NOTE: every signal gets a default before any branch so no latch is inferred.
  always_comb begin
    push       = bus.write_en && (count != DEPTH_C);
    pop        = (state == S_IDLE) && (count != '0);
    baud_end   = (baud_cnt == BAUD_LAST);
    frame_done = (state == S_STOP) && baud_end && (stop_idx == STOP_LAST);
    count_next = count;
    if (push && !pop)      count_next = count + CW'(1);
    else if (!push && pop) count_next = count - CW'(1);
  end

  // NOTE: the storage array has no reset; pointers and count alone say what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.data;
  end

  // Full is judged on the pre-edge count, so a write at full is dropped even when
  // the engine pops at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count  <= count_next;
      full_q <= (count_next == DEPTH_C);
      ovf_q  <= bus.write_en && !push;
      busy_q <= pop || ((state != S_IDLE) && !frame_done) || (count_next != '0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees
  // pre-edge values, whatever order the statements appear in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shift    <= '0;
      par_bit  <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      baud_cnt <= baud_end ? '0 : baud_cnt + BW'(1);
      unique case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          tx_q     <= 1'b1;
          if (pop) begin
            shift   <= mem[rd_ptr];
            par_bit <= (^mem[rd_ptr]) ^ ODD_PARITY;
            tx_q    <= 1'b0;
            state   <= S_START;
          end
        end
        S_START: begin
          if (baud_end) begin
            bit_idx <= '0;
            tx_q    <= shift[0];
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (baud_end) begin
            if (bit_idx == BIT_LAST) begin
              stop_idx <= 1'b0;
              if (HAS_PARITY) begin
                tx_q  <= par_bit;
                state <= S_PARITY;
              end else begin
                tx_q  <= 1'b1;
                state <= S_STOP;
              end
            end else begin
              bit_idx <= bit_idx + IW'(1);
              shift   <= shift >> 1;
              tx_q    <= shift[1];
            end
          end
        end
        S_PARITY: begin
          if (baud_end) begin
            stop_idx <= 1'b0;
            tx_q     <= 1'b1;
            state    <= S_STOP;
          end
        end
        S_STOP: begin
          tx_q <= 1'b1;
          if (baud_end) begin
            if (stop_idx == STOP_LAST) state <= S_IDLE;
            else                       stop_idx <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.tx         = tx_q;
  assign bus.uart_busy  = busy_q;
  assign bus.fifo_full  = full_q;
  assign bus.fifo_count = count;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three configurations (8N1/16, 7O2/4, 8E1/16) at 10 clocks
// per bit, a line monitor per instance checked against a queue of expected frames.
module tb_uart_tx_fifo;
  localparam int DIV = 10;

  typedef struct {
    logic [15:0] bits;   // bits[0] is the start bit, sent first
    int          nbits;
  } frame_t;

  typedef struct {
    logic [7:0] data;
    logic       exp_par;
  } par_vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) bus_a ();
  uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(4))  bus_b ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) bus_c ();

  uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(16))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(2),
                 .STOP_BITS(2), .FIFO_DEPTH(4))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));
  uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(1),
                 .STOP_BITS(1), .FIFO_DEPTH(16))
    dut_c (.clk(clk), .rst(rst), .bus(bus_c.slave));

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc      = 0;
  int          ovf_b    = 0;
  int          frames_done [3];
  logic [15:0] last_bits   [3];
  frame_t      q_a[$], q_b[$], q_c[$];
  int          starts_b[$];
  par_vec_t    tbl [6];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus_b.overflow === 1'b1) ovf_b <= ovf_b + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic frame_t make_frame(input logic [7:0] d, input int dbits, input int pmode,
                                        input int sbits, input int force_par);
    frame_t f;
    logic   p;
    int     n;
    f.bits = '0;
    p = 1'b0;
    n = 1;
    for (int i = 0; i < dbits; i++) begin
      f.bits[n] = d[i];
      p = p ^ d[i];
      n = n + 1;
    end
    if (pmode == 2) p = ~p;
    if (force_par >= 0) p = force_par[0];
    if (pmode != 0) begin
      f.bits[n] = p;
      n = n + 1;
    end
    for (int i = 0; i < sbits; i++) begin
      f.bits[n] = 1'b1;
      n = n + 1;
    end
    f.nbits = n;
    return f;
  endfunction

  function automatic logic tx_of(input int i);
    case (i)
      0:       return bus_a.tx;
      1:       return bus_b.tx;
      default: return bus_c.tx;
    endcase
  endfunction

  function automatic logic [31:0] stat_of(input int i, input int which);
    logic [31:0] r;
    r = '0;
    case (i)
      0: case (which)
           0: r = 32'(bus_a.uart_busy);  1: r = 32'(bus_a.fifo_full);
           2: r = 32'(bus_a.fifo_count); default: r = 32'(bus_a.overflow);
         endcase
      1: case (which)
           0: r = 32'(bus_b.uart_busy);  1: r = 32'(bus_b.fifo_full);
           2: r = 32'(bus_b.fifo_count); default: r = 32'(bus_b.overflow);
         endcase
      default: case (which)
           0: r = 32'(bus_c.uart_busy);  1: r = 32'(bus_c.fifo_full);
           2: r = 32'(bus_c.fifo_count); default: r = 32'(bus_c.overflow);
         endcase
    endcase
    return r;
  endfunction

  task automatic drive(input int i, input logic we, input logic [7:0] d);
    case (i)
      0:       begin bus_a.write_en = we; bus_a.data = d;      end
      1:       begin bus_b.write_en = we; bus_b.data = d[6:0]; end
      default: begin bus_c.write_en = we; bus_c.data = d;      end
    endcase
  endtask

  // Decodes frames from one TX line; every cycle of every bit must match the
  // expected level, so bit widths and start alignment are checked exactly.
  task automatic monitor(input int i);
    frame_t      exp;
    logic [15:0] got;
    logic        prev, v, aborted, have;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      v = tx_of(i);
      if (rst) prev = 1'b1;
      else if (prev === 1'b1 && v === 1'b0) begin
        have = 1'b0;
        case (i)
          0:       if (q_a.size() > 0) begin exp = q_a.pop_front(); have = 1'b1; end
          1:       if (q_b.size() > 0) begin exp = q_b.pop_front(); have = 1'b1; end
          default: if (q_c.size() > 0) begin exp = q_c.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
          check($sformatf("unexpected_frame_%0d", i), 32'd1, 32'd0);
          prev = v;
        end else begin
          if (i == 1) starts_b.push_back(cyc);
          got = '0;
          aborted = 1'b0;
          for (int b = 0; b < exp.nbits && !aborted; b++) begin
            for (int c = 0; c < DIV && !aborted; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              v = tx_of(i);
              if (rst) aborted = 1'b1;
              else if (c == 0) got[b] = v;
              else if (v !== exp.bits[b]) got[b] = v;
            end
          end
          if (!aborted) begin
            check($sformatf("frame_bits_%0d", i), {16'h0, got}, {16'h0, exp.bits});
            last_bits[i] = got;
            frames_done[i]++;
            prev = tx_of(i);
          end else prev = 1'b1;
        end
      end else prev = v;
    end
  endtask

  initial monitor(0);
  initial monitor(1);
  initial monitor(2);

  task automatic wait_frames(input int i, input int target, input int budget, input string name);
    int n = 0;
    while (frames_done[i] < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(frames_done[i]), 32'(target));
  endtask

  // Writes one word at the current negedge; returns one negedge later with write_en low.
  task automatic write1(input int i, input logic [7:0] d);
    drive(i, 1'b1, d);
    @(negedge clk);
    drive(i, 1'b0, 8'h00);
  endtask

  task automatic busy_len(input int i, input int exp_len, input string name);
    int n = 0;
    while (stat_of(i, 0) === 32'd1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check(name, 32'(n), 32'(exp_len));
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, nst;
    tbl[0] = '{8'h03, 1'b0};
    tbl[1] = '{8'h07, 1'b1};
    tbl[2] = '{8'h00, 1'b0};
    tbl[3] = '{8'h80, 1'b1};
    tbl[4] = '{8'hA5, 1'b0};
    tbl[5] = '{8'h6E, 1'b1};
    for (int i = 0; i < 3; i++) begin
      frames_done[i] = 0;
      last_bits[i]   = '0;
      drive(i, 1'b0, 8'h00);
    end

    // Reset values, sampled while rst is still held.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_tx_%0d", i),    32'(tx_of(i)), 32'd1);
      check($sformatf("rst_busy_%0d", i),  stat_of(i, 0), 32'd0);
      check($sformatf("rst_full_%0d", i),  stat_of(i, 1), 32'd0);
      check($sformatf("rst_count_%0d", i), stat_of(i, 2), 32'd0);
      check($sformatf("rst_ovf_%0d", i),   stat_of(i, 3), 32'd0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 8N1, 0x55: start appears one edge after the write edge, 100-cycle frame.
    q_a.push_back(make_frame(8'h55, 8, 0, 1, -1));
    write1(0, 8'h55);
    check("t1_count_after_write", stat_of(0, 2), 32'd1);
    check("t1_busy_after_write",  stat_of(0, 0), 32'd1);
    check("t1_tx_idle_first",     32'(tx_of(0)), 32'd1);
    @(negedge clk);
    check("t1_tx_start",          32'(tx_of(0)), 32'd0);
    check("t1_count_after_pop",   stat_of(0, 2), 32'd0);
    busy_len(0, 100, "t1_busy_len");
    wait_frames(0, 1, 50, "t1_frames");
    repeat (3) @(negedge clk);

    // Reset in the middle of the second frame's data while a third is queued.
    q_a.push_back(make_frame(8'h11, 8, 0, 1, -1));
    q_a.push_back(make_frame(8'h22, 8, 0, 1, -1));
    q_a.push_back(make_frame(8'h33, 8, 0, 1, -1));
    drive(0, 1'b1, 8'h11);
    @(negedge clk); drive(0, 1'b1, 8'h22);
    @(negedge clk); drive(0, 1'b1, 8'h33);
    @(negedge clk); drive(0, 1'b0, 8'h00);
    check("t5_count_push_pop", stat_of(0, 2), 32'd2);
    repeat (148) @(negedge clk);
    check("t5_tx_data_low", 32'(tx_of(0)), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("t5_tx_after_rst",    32'(tx_of(0)), 32'd1);
    check("t5_count_after_rst", stat_of(0, 2), 32'd0);
    check("t5_busy_after_rst",  stat_of(0, 0), 32'd0);
    check("t5_frames_before",   32'(frames_done[0]), 32'd2);
    q_a.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    q_a.push_back(make_frame(8'hA5, 8, 0, 1, -1));
    write1(0, 8'hA5);
    wait_frames(0, 3, 200, "t5_frame_after_rst");
    repeat (3) @(negedge clk);

    // 7O2, 0x41: odd parity 1, two stop bits, 110-cycle frame.
    q_b.push_back(make_frame(8'h41, 7, 2, 2, -1));
    write1(1, 8'h41);
    @(negedge clk);
    check("t2_tx_start", 32'(tx_of(1)), 32'd0);
    busy_len(1, 110, "t2_busy_len");
    wait_frames(1, 1, 50, "t2_frames");
    check("t2_parity_bit", 32'(last_bits[1][8]), 32'd1);
    repeat (3) @(negedge clk);

    // Six back-to-back writes into a 4-deep FIFO: one pops, four queue, one drops.
    base = ovf_b;
    q_b.push_back(make_frame(8'h15, 7, 2, 2, -1));
    q_b.push_back(make_frame(8'h2A, 7, 2, 2, -1));
    q_b.push_back(make_frame(8'h33, 7, 2, 2, -1));
    q_b.push_back(make_frame(8'h4C, 7, 2, 2, -1));
    q_b.push_back(make_frame(8'h5F, 7, 2, 2, -1));
    drive(1, 1'b1, 8'h15);
    @(negedge clk); drive(1, 1'b1, 8'h2A);
    check("t4_count_m0", stat_of(1, 2), 32'd1);
    @(negedge clk); drive(1, 1'b1, 8'h33);
    check("t4_count_push_pop", stat_of(1, 2), 32'd1);
    @(negedge clk); drive(1, 1'b1, 8'h4C);
    @(negedge clk); drive(1, 1'b1, 8'h5F);
    @(negedge clk); drive(1, 1'b1, 8'h60);
    check("t4_count_full", stat_of(1, 2), 32'd4);
    check("t4_full",       stat_of(1, 1), 32'd1);
    check("t4_ovf_before", stat_of(1, 3), 32'd0);
    @(negedge clk); drive(1, 1'b0, 8'h00);
    check("t4_ovf_pulse",     stat_of(1, 3), 32'd1);
    check("t4_count_dropped", stat_of(1, 2), 32'd4);
    @(negedge clk);
    check("t4_ovf_cleared",   stat_of(1, 3), 32'd0);
    wait_frames(1, 6, 5 * 111 + 100, "t4_frames");
    check("t4_ovf_count", 32'(ovf_b - base), 32'd1);
    nst = starts_b.size();
    for (int k = nst - 4; k < nst; k++)
      check($sformatf("t4_gap_%0d", k), 32'(starts_b[k] - starts_b[k-1]), 32'd111);
    repeat (3) @(negedge clk);

    // Write at full on the exact edge the engine pops.
    base = ovf_b;
    q_b.push_back(make_frame(8'h01, 7, 2, 2, -1));
    q_b.push_back(make_frame(8'h02, 7, 2, 2, -1));
    q_b.push_back(make_frame(8'h7F, 7, 2, 2, -1));
    q_b.push_back(make_frame(8'h40, 7, 2, 2, -1));
    q_b.push_back(make_frame(8'h2B, 7, 2, 2, -1));
    drive(1, 1'b1, 8'h01);
    @(negedge clk); drive(1, 1'b1, 8'h02);
    @(negedge clk); drive(1, 1'b1, 8'h7F);
    @(negedge clk); drive(1, 1'b1, 8'h40);
    @(negedge clk); drive(1, 1'b1, 8'h2B);
    @(negedge clk); drive(1, 1'b0, 8'h00);
    repeat (107) @(negedge clk);
    check("t6_count_pre",  stat_of(1, 2), 32'd4);
    check("t6_full_pre",   stat_of(1, 1), 32'd1);
    drive(1, 1'b1, 8'h55);
    @(negedge clk); drive(1, 1'b0, 8'h00);
    check("t6_ovf",        stat_of(1, 3), 32'd1);
    check("t6_count_post", stat_of(1, 2), 32'd3);
    check("t6_full_post",  stat_of(1, 1), 32'd0);
    @(negedge clk);
    check("t6_ovf_cleared", stat_of(1, 3), 32'd0);
    wait_frames(1, 11, 5 * 111 + 100, "t6_frames");
    check("t6_ovf_count", 32'(ovf_b - base), 32'd1);
    repeat (3) @(negedge clk);

    // Even parity table on the 8E1 instance.
    for (int k = 0; k < 6; k++) begin
      q_c.push_back(make_frame(tbl[k].data, 8, 1, 1, 32'(tbl[k].exp_par)));
      write1(2, tbl[k].data);
      check($sformatf("t3_count_%0d", k), stat_of(2, 2), 32'd1);
      wait_frames(2, k + 1, 150, $sformatf("t3_frames_%0d", k));
      check($sformatf("t3_parity_%0d", k), 32'(last_bits[2][9]), 32'(tbl[k].exp_par));
      repeat (3) @(negedge clk);
    end

    check("queues_drained", 32'(q_a.size() + q_b.size() + q_c.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
